// File: rtl/rc5_key_schedule_ctrl.sv
// RC5 key-expansion sequencer: loads L, fills S with the P/Q progression,
// supervises the key mixer and hands the S read port to the cipher when done.
module rc5_key_schedule_ctrl #(
    parameter int            W           = 32,
    parameter int            C           = 4,
    parameter int            T           = 26,
    parameter logic [W-1:0]  P           = 32'hB7E15163,
    parameter logic [W-1:0]  Q           = 32'h9E3779B9,
    parameter int            MIX_TIMEOUT = 4095,
    parameter int            C_LENGTH    = $clog2(C),
    parameter int            T_LENGTH    = $clog2(T)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iStart,
    input  logic                iKeyValid,
    input  logic [W-1:0]        iKeyWord,
    output logic                oKeyReady,
    output logic                oMixRst,
    output logic                oMixStart,
    input  logic                iMixDone,
    input  logic [T_LENGTH-1:0] iMixS_address,
    input  logic                iMixS_we,
    input  logic [W-1:0]        iMixS_data,
    input  logic [C_LENGTH-1:0] iMixL_address,
    input  logic                iMixL_we,
    input  logic [W-1:0]        iMixL_data,
    input  logic [T_LENGTH-1:0] iCipherS_address,
    output logic [T_LENGTH-1:0] oS_address,
    output logic                oS_we,
    output logic [W-1:0]        oS_wdata,
    output logic [C_LENGTH-1:0] oL_address,
    output logic                oL_we,
    output logic [W-1:0]        oL_wdata,
    output logic                oScheduleValid,
    output logic                oError
);

    localparam int CNT_W = ((T_LENGTH > C_LENGTH) ? T_LENGTH : C_LENGTH) + 1;
    localparam int TO_W  = $clog2(MIX_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_L,
        INIT_S,
        MIX_RST,
        MIX_START,
        MIX_RUN,
        READY
    } stateType;

    stateType          state;
    logic [CNT_W-1:0]  wordCnt;
    logic [TO_W-1:0]   timeoutCnt;
    logic [W-1:0]      acc;
    logic              keyReady;
    logic              mixRst;
    logic              mixStart;
    logic              scheduleValid;
    logic              error;
    logic              keyAccept;

    assign keyAccept = iKeyValid && keyReady;

    // Sequencer: a schedule may only be (re)started from IDLE or READY, so
    // a stray iStart while tables are being built cannot corrupt them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wordCnt       <= '0;
            timeoutCnt    <= '0;
            acc           <= P;
            keyReady      <= 1'b0;
            mixRst        <= 1'b0;
            mixStart      <= 1'b0;
            scheduleValid <= 1'b0;
            error         <= 1'b0;
        end else begin
            case (state)
                IDLE, READY: begin
                    if (iStart) begin
                        state         <= LOAD_L;
                        wordCnt       <= '0;
                        keyReady      <= 1'b1;
                        scheduleValid <= 1'b0;
                        error         <= 1'b0;
                    end
                end
                LOAD_L: begin
                    if (keyAccept) begin
                        if (wordCnt == CNT_W'(C - 1)) begin
                            state    <= INIT_S;
                            wordCnt  <= '0;
                            acc      <= P;
                            keyReady <= 1'b0;
                        end else begin
                            wordCnt <= wordCnt + 1'b1;
                        end
                    end
                end
                INIT_S: begin
                    acc <= acc + Q;
                    if (wordCnt == CNT_W'(T - 1)) begin
                        state   <= MIX_RST;
                        wordCnt <= '0;
                        mixRst  <= 1'b1;
                    end else begin
                        wordCnt <= wordCnt + 1'b1;
                    end
                end
                MIX_RST: begin
                    state    <= MIX_START;
                    mixRst   <= 1'b0;
                    mixStart <= 1'b1;
                end
                MIX_START: begin
                    state      <= MIX_RUN;
                    mixStart   <= 1'b0;
                    timeoutCnt <= '0;
                end
                MIX_RUN: begin
                    // Done wins over a timeout landing in the same cycle.
                    if (iMixDone) begin
                        state         <= READY;
                        scheduleValid <= 1'b1;
                    end else if (timeoutCnt == TO_W'(MIX_TIMEOUT)) begin
                        state <= IDLE;
                        error <= 1'b1;
                    end else begin
                        timeoutCnt <= timeoutCnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    keyReady <= 1'b0;
                    mixRst   <= 1'b0;
                    mixStart <= 1'b0;
                end
            endcase
        end
    end

    // RAM port ownership follows the state: controller, mixer or cipher.
    always_comb begin
        oS_address = '0;
        oS_we      = 1'b0;
        oS_wdata   = '0;
        oL_address = '0;
        oL_we      = 1'b0;
        oL_wdata   = '0;
        case (state)
            LOAD_L: begin
                if (keyAccept) begin
                    oL_we      = 1'b1;
                    oL_address = wordCnt[C_LENGTH-1:0];
                    oL_wdata   = iKeyWord;
                end
            end
            INIT_S: begin
                oS_we      = 1'b1;
                oS_address = wordCnt[T_LENGTH-1:0];
                oS_wdata   = acc;
            end
            MIX_RUN: begin
                oS_address = iMixS_address;
                oS_we      = iMixS_we;
                oS_wdata   = iMixS_data;
                oL_address = iMixL_address;
                oL_we      = iMixL_we;
                oL_wdata   = iMixL_data;
            end
            READY: begin
                oS_address = iCipherS_address;
            end
            default: begin
                oS_we = 1'b0;
            end
        endcase
    end

    assign oKeyReady      = keyReady;
    assign oMixRst        = mixRst;
    assign oMixStart      = mixStart;
    assign oScheduleValid = scheduleValid;
    assign oError         = error;

endmodule

// File: tb/tb_rc5_key_schedule_ctrl.sv
// Randomized bench for rc5_key_schedule_ctrl; RAM writes are logged and
// compared against the arithmetic P + i*Q table and the supplied key words.
module tb_rc5_key_schedule_ctrl;

    localparam int           W           = 32;
    localparam int           C           = 4;
    localparam int           T           = 26;
    localparam logic [W-1:0] P           = 32'hB7E15163;
    localparam logic [W-1:0] Q           = 32'h9E3779B9;
    localparam int           MIX_TIMEOUT = 4095;
    localparam int           C_LENGTH    = $clog2(C);
    localparam int           T_LENGTH    = $clog2(T);

    typedef logic [W-1:0] keyArrType [C];

    logic                clk = 1'b0;
    logic                rst;
    logic                iStart;
    logic                iKeyValid;
    logic [W-1:0]        iKeyWord;
    logic                oKeyReady;
    logic                oMixRst;
    logic                oMixStart;
    logic                iMixDone;
    logic [T_LENGTH-1:0] iMixS_address;
    logic                iMixS_we;
    logic [W-1:0]        iMixS_data;
    logic [C_LENGTH-1:0] iMixL_address;
    logic                iMixL_we;
    logic [W-1:0]        iMixL_data;
    logic [T_LENGTH-1:0] iCipherS_address;
    logic [T_LENGTH-1:0] oS_address;
    logic                oS_we;
    logic [W-1:0]        oS_wdata;
    logic [C_LENGTH-1:0] oL_address;
    logic                oL_we;
    logic [W-1:0]        oL_wdata;
    logic                oScheduleValid;
    logic                oError;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]   lAddrLog[$];
    logic [W-1:0] lDataLog[$];
    logic [7:0]   sAddrLog[$];
    logic [W-1:0] sDataLog[$];

    rc5_key_schedule_ctrl #(
        .W(W), .C(C), .T(T), .P(P), .Q(Q), .MIX_TIMEOUT(MIX_TIMEOUT),
        .C_LENGTH(C_LENGTH), .T_LENGTH(T_LENGTH)
    ) dut (
        .clk(clk), .rst(rst), .iStart(iStart), .iKeyValid(iKeyValid),
        .iKeyWord(iKeyWord), .oKeyReady(oKeyReady), .oMixRst(oMixRst),
        .oMixStart(oMixStart), .iMixDone(iMixDone),
        .iMixS_address(iMixS_address), .iMixS_we(iMixS_we), .iMixS_data(iMixS_data),
        .iMixL_address(iMixL_address), .iMixL_we(iMixL_we), .iMixL_data(iMixL_data),
        .iCipherS_address(iCipherS_address), .oS_address(oS_address),
        .oS_we(oS_we), .oS_wdata(oS_wdata), .oL_address(oL_address),
        .oL_we(oL_we), .oL_wdata(oL_wdata), .oScheduleValid(oScheduleValid),
        .oError(oError)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected S initialisation value, straight from the P + i*Q definition.
    function automatic logic [W-1:0] sModel(input int i);
        return P + W'(i) * Q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scrambleMixer();
        iMixS_address = T_LENGTH'($urandom_range(0, T - 1));
        iMixS_we      = 1'b1;
        iMixS_data    = $urandom;
        iMixL_address = C_LENGTH'($urandom_range(0, C - 1));
        iMixL_we      = 1'b1;
        iMixL_data    = $urandom;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (oL_we) begin
                lAddrLog.push_back(8'(oL_address));
                lDataLog.push_back(oL_wdata);
            end
            if (oS_we) begin
                sAddrLog.push_back(8'(oS_address));
                sDataLog.push_back(oS_wdata);
            end
            if (oMixRst || oMixStart)
                checkOutput("mixExclusive", 64'(oMixRst & oMixStart), 64'd0);
        end
    end

    task automatic startSchedule();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "KeyReady"}, 64'(oKeyReady), 64'd0);
        checkOutput({tag, "SWe"}, 64'(oS_we), 64'd0);
        checkOutput({tag, "LWe"}, 64'(oL_we), 64'd0);
        checkOutput({tag, "MixRst"}, 64'(oMixRst), 64'd0);
        checkOutput({tag, "MixStart"}, 64'(oMixStart), 64'd0);
        checkOutput({tag, "Valid"}, 64'(oScheduleValid), 64'd0);
        checkOutput({tag, "SAddr"}, 64'(oS_address), 64'd0);
        checkOutput({tag, "LAddr"}, 64'(oL_address), 64'd0);
    endtask

    // Feed the key (patMode 0 = always valid, 1 = fixed backpressure, 2 = random),
    // walk INIT_S and the mixer handshake, then compare the logged writes.
    task automatic applyStimulus(input keyArrType keys, input int patMode,
                                 input bit pulseIgnored, input int abortAt);
        int bpPat[7] = '{1, 0, 0, 1, 1, 0, 1};
        int idx = 0;
        int n = 0;
        bit v;
        lAddrLog.delete(); lDataLog.delete();
        sAddrLog.delete(); sDataLog.delete();
        scrambleMixer();
        while (idx < C && n < 64) begin
            case (patMode)
                0: v = 1'b1;
                1: v = (n < 7) ? bpPat[n][0] : 1'b1;
                default: v = $urandom_range(0, 1) == 1;
            endcase
            iKeyValid = v;
            iKeyWord  = v ? keys[idx] : $urandom;
            @(negedge clk);
            checkOutput("keyReady", 64'(oKeyReady), 64'd1);
            checkOutput("validLowInLoad", 64'(oScheduleValid), 64'd0);
            checkOutput("errorLowInLoad", 64'(oError), 64'd0);
            tick();
            if (v) idx++;
            n++;
        end
        iKeyValid = 1'b0;
        checkOutput("keysAccepted", 64'(idx), 64'(C));
        for (int i = 0; i < T; i++) begin
            iStart    = pulseIgnored && (i == 5);
            iKeyValid = (i == 7);
            if (i == abortAt) begin
                iStart = 1'b0;
                rst = 1'b1;
                tick();
                rst = 1'b0;
                @(negedge clk);
                checkIdle("abort");
                checkOutput("abortError", 64'(oError), 64'd0);
                tick();
                return;
            end
            @(negedge clk);
            checkOutput("initKeyReady", 64'(oKeyReady), 64'd0);
            tick();
        end
        iStart    = 1'b0;
        iKeyValid = 1'b0;
        @(negedge clk);
        checkOutput("mixRstPulse", 64'(oMixRst), 64'd1);
        checkOutput("mixRstNoSWe", 64'(oS_we), 64'd0);
        tick();
        iMixDone = 1'b0;
        @(negedge clk);
        checkOutput("mixStartPulse", 64'(oMixStart), 64'd1);
        checkOutput("mixRstDropped", 64'(oMixRst), 64'd0);
        tick();
        checkOutput("lCount", 64'(lAddrLog.size()), 64'(C));
        for (int i = 0; i < C && i < lAddrLog.size(); i++) begin
            checkOutput("lAddr", 64'(lAddrLog[i]), 64'(i));
            checkOutput("lData", 64'(lDataLog[i]), 64'(keys[i]));
        end
        checkOutput("sCount", 64'(sAddrLog.size()), 64'(T));
        for (int i = 0; i < T && i < sAddrLog.size(); i++) begin
            checkOutput("sAddr", 64'(sAddrLog[i]), 64'(i));
            checkOutput("sData", 64'(sDataLog[i]), 64'(sModel(i)));
        end
    endtask

    task automatic checkMagicWords();
        checkOutput("s0Literal", 64'(sDataLog[0]), 64'h0B7E15163);
        checkOutput("s1Literal", 64'(sDataLog[1]), 64'h05618CB1C);
        checkOutput("s2Literal", 64'(sDataLog[2]), 64'h0F45044D5);
    endtask

    // Mixer model: random forwarded writes, then done with a final S write.
    task automatic runMixer(input int delay);
        for (int d = 0; d < delay; d++) begin
            iMixDone      = 1'b0;
            iMixS_we      = $urandom_range(0, 1) == 1;
            iMixS_address = T_LENGTH'($urandom_range(0, T - 1));
            iMixS_data    = $urandom;
            iMixL_we      = $urandom_range(0, 1) == 1;
            iMixL_address = C_LENGTH'($urandom_range(0, C - 1));
            iMixL_data    = $urandom;
            @(negedge clk);
            checkOutput("fwdSWe", 64'(oS_we), 64'(iMixS_we));
            checkOutput("fwdSAddr", 64'(oS_address), 64'(iMixS_address));
            checkOutput("fwdSData", 64'(oS_wdata), 64'(iMixS_data));
            checkOutput("fwdLWe", 64'(oL_we), 64'(iMixL_we));
            checkOutput("fwdLAddr", 64'(oL_address), 64'(iMixL_address));
            checkOutput("fwdLData", 64'(oL_wdata), 64'(iMixL_data));
            checkOutput("runValidLow", 64'(oScheduleValid), 64'd0);
            tick();
        end
        iMixDone      = 1'b1;
        iMixS_we      = 1'b1;
        iMixS_address = T_LENGTH'(25);
        iMixS_data    = 32'h12345678;
        iMixL_we      = 1'b0;
        @(negedge clk);
        checkOutput("doneSWe", 64'(oS_we), 64'd1);
        checkOutput("doneSAddr", 64'(oS_address), 64'd25);
        checkOutput("doneSData", 64'(oS_wdata), 64'h12345678);
        checkOutput("doneValidLow", 64'(oScheduleValid), 64'd0);
        tick();
        scrambleMixer();
        iCipherS_address = T_LENGTH'(7);
        @(negedge clk);
        checkOutput("readyValid", 64'(oScheduleValid), 64'd1);
        checkOutput("readySAddr", 64'(oS_address), 64'd7);
        checkOutput("readySWe", 64'(oS_we), 64'd0);
        checkOutput("readyLWe", 64'(oL_we), 64'd0);
        checkOutput("readyLAddr", 64'(oL_address), 64'd0);
        checkOutput("readyKeyReady", 64'(oKeyReady), 64'd0);
        checkOutput("readyError", 64'(oError), 64'd0);
        tick();
        iCipherS_address = T_LENGTH'($urandom_range(0, T - 1));
        @(negedge clk);
        checkOutput("readySAddrRand", 64'(oS_address), 64'(iCipherS_address));
        tick();
    endtask

    task automatic runTimeout();
        iMixDone = 1'b0;
        for (int k = 0; k <= MIX_TIMEOUT; k++) begin
            scrambleMixer();
            if (k == 0 || k == MIX_TIMEOUT) begin
                @(negedge clk);
                checkOutput("toNoErrorYet", 64'(oError), 64'd0);
                checkOutput("toFwdSAddr", 64'(oS_address), 64'(iMixS_address));
            end
            tick();
        end
        scrambleMixer();
        @(negedge clk);
        checkOutput("toError", 64'(oError), 64'd1);
        checkIdle("timeout");
        tick();
        @(negedge clk);
        checkOutput("toErrorSticky", 64'(oError), 64'd1);
        tick();
    endtask

    function automatic keyArrType randomKeys();
        keyArrType k;
        for (int i = 0; i < C; i++) k[i] = $urandom;
        return k;
    endfunction

    initial begin
        keyArrType zeroKeys;
        for (int i = 0; i < C; i++) zeroKeys[i] = '0;
        rst = 1'b1; iStart = 1'b0; iKeyValid = 1'b0; iKeyWord = '0;
        iMixDone = 1'b0; iMixS_address = '0; iMixS_we = 1'b0; iMixS_data = '0;
        iMixL_address = '0; iMixL_we = 1'b0; iMixL_data = '0; iCipherS_address = '0;
        repeat (3) tick();
        @(negedge clk);
        checkIdle("reset");
        checkOutput("resetError", 64'(oError), 64'd0);
        checkOutput("resetSData", 64'(oS_wdata), 64'd0);
        checkOutput("resetLData", 64'(oL_wdata), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] full schedule, zero key");
        startSchedule();
        applyStimulus(zeroKeys, 0, 1'b0, -1);
        checkMagicWords();
        runMixer($urandom_range(0, 5));

        $display("[TB] rekey from READY, backpressure, ignored start, timeout");
        startSchedule();
        applyStimulus(randomKeys(), 1, 1'b1, -1);
        runTimeout();

        $display("[TB] restart from IDLE with random valid pattern");
        startSchedule();
        applyStimulus(randomKeys(), 2, 1'b0, -1);
        runMixer($urandom_range(0, 8));

        $display("[TB] reset in the middle of INIT_S");
        startSchedule();
        applyStimulus(randomKeys(), 0, 1'b0, 10);
        startSchedule();
        applyStimulus(zeroKeys, 0, 1'b0, -1);
        checkMagicWords();
        runMixer(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
